instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential instruction fetch stage that produces the instruction stream consumed by the opcode decoder (`control_unit`). The block holds the PC and issues one instruction-memory read at a time. It captures each returned word and presents it, with its PC and the decoded opcode field, to the decode stage over a valid/ready handshake. Branch and jump redirects arriving from the execute side steer the PC and squash in-flight or held instructions.

## Interface
Parameters:
- `ADDR_W`, 32, PC / instruction-memory address width
- `DATA_W`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  in  1  system clock, rising edge
- `arst_n`  in  1  reset; asynchronous, active-low
- `imem_req`  out  1  read request strobe, one cycle per request
- `imem_addr`  out  ADDR_W  read address, valid while `imem_req`=1
- `imem_rvalid`  in  1  read data valid, ≥1 cycle after the request
- `imem_rdata`  in  DATA_W  returned instruction word
- `instr_valid`  out  1  instruction available to decode
- `instr_ready`  in  1  decode accepts the instruction
- `instr`  out  DATA_W  held instruction word
- `opcode`  out  6  `instr[31:26]`, fed to `control_unit.opcode`
- `instr_pc`  out  ADDR_W  PC of the held instruction
- `redirect_valid`  in  1  branch taken or jump
- `redirect_pc`  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- **IDLE:** entered on reset. Always moves to REQ on the next cycle.
- **REQ:** `imem_req`=1 and `imem_addr`=`pc`. Moves to WAIT.
- **WAIT:**
  - On `imem_rvalid` with the kill flag clear: capture `imem_rdata` into `instr` and `pc` into `instr_pc`, set `pc`←`pc`+4, move to HOLD.
  - On `imem_rvalid` with the kill flag set: discard the word, clear kill, move to REQ.
- **HOLD:** `instr_valid`=1. On `instr_ready`: handshake completes and the block moves to REQ.
- **Redirect handling:**
  - `redirect_valid` in REQ: `pc`←target; the request issued this cycle is marked killed.
  - `redirect_valid` in WAIT: `pc`←target and kill is set. If `imem_rvalid` arrives in the same cycle, that word is discarded and the block moves to REQ.
  - `redirect_valid` in HOLD: drop the held instruction, `instr_valid`→0, `pc`←target, move to REQ. If `instr_ready` is high in the same cycle, the handshake still counts as completed and the next fetch uses the target.
  - `redirect_valid` in IDLE: `pc`←target.
- **PC arithmetic:** modulo 2^ADDR_W. 32'hFFFF_FFFC+4 wraps to 0.
- **Ordering rules:**
  - At most one outstanding request.
  - `imem_rvalid` outside WAIT is ignored, including stale responses after a reset.
  - Outputs `instr`, `instr_pc`, `opcode` are stable while `instr_valid`=1 and `instr_ready`=0.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `opcode`=0, `instr_pc`=0
  - internal `pc`=RESET_PC, kill=0, state IDLE
- **First request:** cycle 1 after `arst_n` deasserts synchronously to `clk`.
- **Latency:** `instr_valid` rises on the cycle after the accepted `imem_rvalid`.
- **Throughput:** with 1-cycle memory and `instr_ready` held high, one instruction every 3 cycles (REQ, WAIT, HOLD).
- **Outputs:** all are registered. `opcode` is a wire slice of the `instr` register.
- **Reset during operation:** `arst_n` low forces all reset values immediately, regardless of state; a pending response is lost.

## Structure
- Shared package `fetch_pkg` holds:
  - state enum `fetch_state_t` (IDLE, REQ, WAIT, HOLD)
  - `PC_STEP`=4
  - `OPCODE_MSB`=31, `OPCODE_LSB`=26, shared with `control_unit`'s opcode constants (`ALU_R`, `ADDI`, `BRANCH_EQ`, `JUMP`, `LOAD_WORD`, `STORE_WORD`)
- No sub-module; the PC register, incrementer and instruction holding register live inline.

## Test plan
- **Reset and first fetch:** reset with RESET_PC=0, 1-cycle memory returning 32'h2008_0005 (ADDI) -> `imem_req` at cycle 1 with `imem_addr`=0; `instr_valid` at cycle 3 with `opcode`=6'h08 and `instr_pc`=0; next request to address 4.
- **Stall:** `instr_ready`=0 for 5 cycles while holding 32'h8C01_0010 (LW) -> `instr`, `opcode`=6'h23 and `instr_pc` stay constant and no new `imem_req` is issued; one cycle after ready rises, request to `instr_pc`+4.
- **Redirect in WAIT:** redirect to 32'h0000_0040 while a response is pending, 3-cycle memory -> the returned word never raises `instr_valid`; the next `imem_addr`=0x40 and the next `instr_pc`=0x40.
- **Redirect in HOLD with simultaneous ready:** -> `instr_valid` falls, exactly one handshake is counted, next `imem_addr`=target; `redirect_pc`=0x43 yields address 0x40.
- **Wrap:** PC=32'hFFFF_FFFC -> after that fetch, next `imem_addr`=0.
- **Reset in WAIT:** `arst_n` pulsed low mid-WAIT, late `imem_rvalid` arrives in IDLE -> ignored; the fetch restarts at RESET_PC and all outputs show reset values during reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, PC step and the opcode field
// location and values common with the decoder (control_unit).
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    localparam int PC_STEP    = 4;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    // Opcode values recognised by control_unit
    localparam logic [5:0] ALU_R      = 6'h00;
    localparam logic [5:0] JUMP       = 6'h02;
    localparam logic [5:0] BRANCH_EQ  = 6'h04;
    localparam logic [5:0] ADDI       = 6'h08;
    localparam logic [5:0] LOAD_WORD  = 6'h23;
    localparam logic [5:0] STORE_WORD = 6'h2B;

endpackage

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: one outstanding imem read at a time, the returned
// word is held for decode over valid/ready, and redirects steer the PC and squash.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              arst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    fetch_state_t      state, next_state;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] target;
    logic              kill, kill_next;
    logic              capture;

    // Redirect targets are always word aligned
    assign target = redirect_pc & ~ADDR_W'(3);
    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];

    always_comb begin
        next_state = state;
        pc_next    = pc;
        kill_next  = kill;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                next_state = REQ;
                if (redirect_valid) pc_next = target;
            end
            REQ: begin
                next_state = WAIT;
                if (redirect_valid) begin
                    pc_next   = target;
                    kill_next = 1'b1;
                end
            end
            WAIT: begin
                // A redirect arriving with the response squashes that word too
                if (imem_rvalid) begin
                    if (kill || redirect_valid) begin
                        kill_next  = 1'b0;
                        next_state = REQ;
                        if (redirect_valid) pc_next = target;
                    end else begin
                        capture    = 1'b1;
                        pc_next    = pc + ADDR_W'(PC_STEP);
                        next_state = HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_next   = target;
                    kill_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = target;
                    next_state = REQ;
                end else if (instr_ready) begin
                    next_state = REQ;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            kill        <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state       <= next_state;
            pc          <= pc_next;
            kill        <= kill_next;
            imem_req    <= (next_state == REQ);
            instr_valid <= (next_state == HOLD);
            if (next_state == REQ) imem_addr <= pc_next;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a memory responder with variable latency
// and a transaction-level model of requests, deliveries, redirects and stalls.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    // Model of the fetch stream, advanced once per cycle from the bench's own inputs
    logic [31:0] m_next_pc, m_p_addr, m_held_word, m_held_pc;
    bit          m_pending, m_killed, m_exp_req, m_exp_valid, m_after_reset;
    int          m_cnt;

    int          lat_min, lat_max, ready_pct, redir_pct, spur_pct;
    bit          stale_rvalid, idle_redirect;
    logic [31:0] idle_target;
    int          cyc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .opcode        (opcode),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h8C01_0010;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Asynchronous reset taken mid-cycle, optional stale response, synchronous release
    task automatic applyReset(input bit stale);
        arst_n         = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checkOutput("rst_req", imem_req, 1'b0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_valid", instr_valid, 1'b0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_opcode", opcode, 6'h00);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        @(posedge clk);
        imem_rvalid = stale;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("rst_hold_req", imem_req, 1'b0);
        checkOutput("rst_hold_valid", instr_valid, 1'b0);
        imem_rvalid   = 1'b0;
        arst_n        = 1'b1;
        m_next_pc     = 32'h0;
        m_pending     = 1'b0;
        m_killed      = 1'b0;
        m_exp_req     = 1'b0;
        m_exp_valid   = 1'b0;
        m_after_reset = 1'b1;
        stale_rvalid  = stale;
        cyc           = 0;
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model
    task automatic applyStimulus();
        bit          rdy, redir, rv, resp, nreq, nvalid;
        logic [31:0] tgt, rdata;
        checkOutput("req", imem_req, m_exp_req);
        checkOutput("valid", instr_valid, m_exp_valid);
        if (imem_req) checkOutput("addr", imem_addr, m_next_pc);
        if (instr_valid) begin
            checkOutput("instr", instr, m_held_word);
            checkOutput("instr_pc", instr_pc, m_held_pc);
            checkOutput("opcode", opcode, m_held_word[31:26]);
        end
        rdy   = ($urandom_range(99) < ready_pct);
        redir = ($urandom_range(99) < redir_pct);
        tgt   = $urandom;
        if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        if (m_after_reset && idle_redirect) begin
            redir = 1'b1;
            tgt   = idle_target;
        end
        resp  = 1'b0;
        rv    = 1'b0;
        rdata = $urandom;
        if (m_pending && !m_exp_req) begin
            m_cnt--;
            if (m_cnt == 0) begin
                resp  = 1'b1;
                rv    = 1'b1;
                rdata = mem_word(m_p_addr);
            end
        end else if (!m_pending && !m_exp_req &&
                     (($urandom_range(99) < spur_pct) || (m_after_reset && stale_rvalid))) begin
            rv = 1'b1;
        end
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rvalid    = rv;
        imem_rdata     = rdata;

        nreq   = m_after_reset;
        nvalid = 1'b0;
        if (m_exp_req) begin
            m_pending = 1'b1;
            m_p_addr  = m_next_pc;
            m_killed  = redir;
            m_cnt     = $urandom_range(lat_max, lat_min);
        end else if (m_pending && resp) begin
            m_pending = 1'b0;
            if (m_killed || redir) begin
                nreq = 1'b1;
            end else begin
                m_held_word = mem_word(m_p_addr);
                m_held_pc   = m_p_addr;
                m_next_pc   = m_p_addr + 32'd4;
                nvalid      = 1'b1;
            end
        end else if (m_pending && redir) begin
            m_killed = 1'b1;
        end
        if (m_exp_valid) begin
            if (redir || rdy) nreq = 1'b1;
            else nvalid = 1'b1;
        end
        if (redir) m_next_pc = tgt & ~32'h3;
        m_exp_req     = nreq;
        m_exp_valid   = nvalid;
        m_after_reset = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic setKnobs(input int lmin, input int lmax, input int rp, input int dp, input int sp);
        lat_min   = lmin;
        lat_max   = lmax;
        ready_pct = rp;
        redir_pct = dp;
        spur_pct  = sp;
    endtask

    initial begin
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        idle_redirect  = 1'b0;
        idle_target    = 32'h0;
        setKnobs(1, 1, 100, 0, 0);

        // First fetch, then a five-cycle stall on the LW at address 4
        applyReset(1'b0);
        for (int i = 0; i < 16; i++) begin
            ready_pct = (cyc >= 6 && cyc <= 10) ? 0 : 100;
            if (cyc == 1) begin
                checkOutput("first_req", imem_req, 1'b1);
                checkOutput("first_addr", imem_addr, 32'h0);
            end
            if (cyc == 3) begin
                checkOutput("first_valid", instr_valid, 1'b1);
                checkOutput("first_opcode", opcode, 6'h08);
            end
            if (cyc == 4) checkOutput("second_addr", imem_addr, 32'h4);
            if (cyc >= 6 && cyc <= 11) begin
                checkOutput("stall_opcode", opcode, 6'h23);
                checkOutput("stall_instr_pc", instr_pc, 32'h4);
            end
            if (cyc >= 7 && cyc <= 11) checkOutput("stall_no_req", imem_req, 1'b0);
            if (cyc == 12) checkOutput("after_stall_addr", imem_addr, 32'h8);
            applyStimulus();
        end

        // Heavy backpressure
        setKnobs(1, 2, 15, 0, 10);
        for (int i = 0; i < 60; i++) applyStimulus();

        // Mixed random traffic with redirects
        setKnobs(1, 3, 60, 10, 10);
        for (int i = 0; i < 300; i++) applyStimulus();

        // Redirect in IDLE to the top word, next fetch wraps to 0
        idle_redirect = 1'b1;
        idle_target   = 32'hFFFF_FFFF;
        setKnobs(1, 1, 100, 0, 0);
        applyReset(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (cyc == 1) checkOutput("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
            if (cyc == 3) checkOutput("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
            if (cyc == 4) checkOutput("wrap_next_addr", imem_addr, 32'h0);
            applyStimulus();
        end
        idle_redirect = 1'b0;

        // Reset while a slow response is outstanding; it arrives late in IDLE
        setKnobs(3, 3, 100, 0, 0);
        for (int i = 0; i < 20 && !(m_pending && !m_exp_req); i++) applyStimulus();
        checkOutput("reached_wait", m_pending && !m_exp_req, 1'b1);
        applyReset(1'b1);
        checkOutput("post_rst_req", imem_req, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (cyc == 1) checkOutput("restart_addr", imem_addr, 32'h0);
            applyStimulus();
        end

        // Slow memory with frequent redirects, then everything mixed
        setKnobs(3, 3, 70, 15, 5);
        for (int i = 0; i < 150; i++) applyStimulus();
        setKnobs(1, 3, 50, 15, 10);
        for (int i = 0; i < 300; i++) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
